// File: rtl/spi_reg_bank.sv
// Register bank behind the SPI slave: live MPPT shadows, sticky fault flags,
// a saturating measurement counter and a coherent snapshot for burst reads.
module spi_reg_bank #(
    parameter logic [7:0] ID_VALUE = 8'hA5,
    parameter logic [7:0] VERSION  = 8'h01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  reg_addr,
    input  logic        reg_read,
    output logic [7:0]  reg_rdata,
    input  logic        meas_valid,
    input  logic [15:0] v_pv,
    input  logic [15:0] i_pv,
    input  logic [31:0] p_pv,
    input  logic [15:0] duty,
    input  logic        tracking,
    input  logic        fault_ovp,
    input  logic        fault_ocp,
    output logic        data_ready
);

    logic [15:0] live_v_q, live_i_q, live_duty_q;
    logic [31:0] live_p_q;
    logic [15:0] snap_v_q, snap_i_q, snap_duty_q;
    logic [31:0] snap_p_q;
    logic [7:0]  meas_cnt_q, meas_cnt_d;
    logic        data_ready_q, data_ready_d;
    logic        ovp_q, ovp_d, ocp_q, ocp_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [7:0]  rd_byte;
    logic        snap_trig, status_rd;

    assign snap_trig = reg_read && (reg_addr == 8'h03);
    assign status_rd = reg_read && (reg_addr == 8'h02);

    // Read mux always sees pre-side-effect state; big-endian byte order.
    always_comb begin
        rd_byte = 8'h00;
        case (reg_addr)
            8'h00:   rd_byte = ID_VERSION_SEL(1'b0);
            8'h01:   rd_byte = ID_VERSION_SEL(1'b1);
            8'h02:   rd_byte = {4'b0000, data_ready_q, tracking, ocp_q, ovp_q};
            8'h03:   rd_byte = meas_cnt_q;
            8'h04:   rd_byte = snap_v_q[15:8];
            8'h05:   rd_byte = snap_v_q[7:0];
            8'h06:   rd_byte = snap_i_q[15:8];
            8'h07:   rd_byte = snap_i_q[7:0];
            8'h08:   rd_byte = snap_p_q[31:24];
            8'h09:   rd_byte = snap_p_q[23:16];
            8'h0A:   rd_byte = snap_p_q[15:8];
            8'h0B:   rd_byte = snap_p_q[7:0];
            8'h0C:   rd_byte = snap_duty_q[15:8];
            8'h0D:   rd_byte = snap_duty_q[7:0];
            default: rd_byte = 8'h00;
        endcase
    end

    function automatic logic [7:0] ID_VERSION_SEL(input logic sel);
        return sel ? VERSION : ID_VALUE;
    endfunction

    always_comb begin
        rdata_d      = reg_read ? rd_byte : rdata_q;
        meas_cnt_d   = meas_cnt_q;
        data_ready_d = data_ready_q;
        // A fresh pulse wins over a clear in the same cycle.
        ovp_d        = fault_ovp || (ovp_q && !status_rd);
        ocp_d        = fault_ocp || (ocp_q && !status_rd);
        if (snap_trig) begin
            meas_cnt_d   = meas_valid ? 8'd1 : 8'd0;
            data_ready_d = meas_valid;
        end else if (meas_valid) begin
            data_ready_d = 1'b1;
            if (meas_cnt_q != 8'hFF) meas_cnt_d = meas_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_v_q     <= '0;
            live_i_q     <= '0;
            live_p_q     <= '0;
            live_duty_q  <= '0;
            snap_v_q     <= '0;
            snap_i_q     <= '0;
            snap_p_q     <= '0;
            snap_duty_q  <= '0;
            meas_cnt_q   <= '0;
            data_ready_q <= 1'b0;
            ovp_q        <= 1'b0;
            ocp_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            rdata_q      <= rdata_d;
            meas_cnt_q   <= meas_cnt_d;
            data_ready_q <= data_ready_d;
            ovp_q        <= ovp_d;
            ocp_q        <= ocp_d;
            // Snapshot takes the old live values even when a sample lands now.
            if (snap_trig) begin
                snap_v_q    <= live_v_q;
                snap_i_q    <= live_i_q;
                snap_p_q    <= live_p_q;
                snap_duty_q <= live_duty_q;
            end
            if (meas_valid) begin
                live_v_q    <= v_pv;
                live_i_q    <= i_pv;
                live_p_q    <= p_pv;
                live_duty_q <= duty;
            end
        end
    end

    assign reg_rdata  = rdata_q;
    assign data_ready = data_ready_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: directed tables and sequences, then random traffic
// checked against a byte-image reference model.
module tb_spi_reg_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  reg_addr = '0;
    logic        reg_read = 1'b0;
    logic [7:0]  reg_rdata;
    logic        meas_valid = 1'b0;
    logic [15:0] v_pv = '0, i_pv = '0, duty = '0;
    logic [31:0] p_pv = '0;
    logic        tracking = 1'b0;
    logic        fault_ovp = 1'b0, fault_ocp = 1'b0;
    logic        data_ready;

    int checks = 0;
    int failures = 0;

    spi_reg_bank dut (
        .clk(clk), .rst(rst), .reg_addr(reg_addr), .reg_read(reg_read),
        .reg_rdata(reg_rdata), .meas_valid(meas_valid), .v_pv(v_pv),
        .i_pv(i_pv), .p_pv(p_pv), .duty(duty), .tracking(tracking),
        .fault_ovp(fault_ovp), .fault_ocp(fault_ocp), .data_ready(data_ready)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_v, m_i, m_d, s_v, s_i, s_d;
    logic [31:0] m_p, s_p;
    logic [7:0]  m_cnt, m_rdata;
    logic        m_ovp, m_ocp, m_dr;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
    } vec_t;

    vec_t reset_tbl[4];
    vec_t burst_tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_v = 0; m_i = 0; m_d = 0; m_p = 0;
        s_v = 0; s_i = 0; s_d = 0; s_p = 0;
        m_cnt = 0; m_rdata = 0; m_ovp = 0; m_ocp = 0; m_dr = 0;
    endtask

    function automatic logic [7:0] model_byte(input logic [7:0] a);
        logic [79:0] img;
        int k;
        img = {s_v, s_i, s_p, s_d};
        if (a == 8'h00) return 8'hA5;
        if (a == 8'h01) return 8'h01;
        if (a == 8'h02) return {4'b0, m_dr, tracking, m_ocp, m_ovp};
        if (a == 8'h03) return m_cnt;
        if (a >= 8'h04 && a <= 8'h0D) begin
            k = 13 - int'(a);
            return 8'(img >> (8 * k));
        end
        return 8'h00;
    endfunction

    // Apply the rules in order: read value, read side effects, then events.
    task automatic model_step(input logic rd, input logic [7:0] a, input logic mv,
                              input logic [15:0] v, input logic [15:0] i,
                              input logic [31:0] p, input logic [15:0] d,
                              input logic fo, input logic fc);
        if (rd) begin
            m_rdata = model_byte(a);
            if (a == 8'h02) begin m_ovp = 0; m_ocp = 0; end
            if (a == 8'h03) begin
                s_v = m_v; s_i = m_i; s_p = m_p; s_d = m_d;
                m_cnt = 0; m_dr = 0;
            end
        end
        if (fo) m_ovp = 1;
        if (fc) m_ocp = 1;
        if (mv) begin
            m_v = v; m_i = i; m_p = p; m_d = d;
            m_dr = 1;
            if (m_cnt < 8'hFF) m_cnt = m_cnt + 1;
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic cyc(input logic rd, input logic [7:0] a, input logic mv,
                       input logic [15:0] v, input logic [15:0] i,
                       input logic [31:0] p, input logic [15:0] d,
                       input logic fo, input logic fc);
        reg_read = rd; reg_addr = a; meas_valid = mv;
        v_pv = v; i_pv = i; p_pv = p; duty = d;
        fault_ovp = fo; fault_ocp = fc;
        model_step(rd, a, mv, v, i, p, d, fo, fc);
        @(negedge clk);
        reg_read = 0; meas_valid = 0; fault_ovp = 0; fault_ocp = 0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] data);
        cyc(1, a, 0, 0, 0, 0, 0, 0, 0);
        data = reg_rdata;
    endtask

    task automatic meas(input logic [15:0] v, input logic [15:0] i,
                        input logic [31:0] p, input logic [15:0] d);
        cyc(0, 8'h00, 1, v, i, p, d, 0, 0);
    endtask

    // Reset asserted mid-cycle while a read strobe is pending.
    task automatic do_reset();
        @(negedge clk);
        reg_read = 1; reg_addr = 8'h00;
        #2 rst = 1;
        #1 reg_read = 0;
        @(negedge clk);
        check("rst_rdata", reg_rdata, 8'h00);
        check("rst_data_ready", data_ready, 1'b0);
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    initial begin
        logic [7:0] b;
        reset_tbl[0] = '{8'h00, 8'hA5};
        reset_tbl[1] = '{8'h01, 8'h01};
        reset_tbl[2] = '{8'h02, 8'h00};
        reset_tbl[3] = '{8'h04, 8'h00};
        burst_tbl[0] = '{8'h04, 8'h12};
        burst_tbl[1] = '{8'h05, 8'h34};
        burst_tbl[2] = '{8'h06, 8'h05};
        burst_tbl[3] = '{8'h07, 8'h67};
        burst_tbl[4] = '{8'h08, 8'h89};
        burst_tbl[5] = '{8'h09, 8'hAB};
        burst_tbl[6] = '{8'h0A, 8'hCD};
        burst_tbl[7] = '{8'h0B, 8'hEF};
        burst_tbl[8] = '{8'h0C, 8'h40};
        burst_tbl[9] = '{8'h0D, 8'h00};

        // Reset values
        do_reset();
        for (int k = 0; k < 4; k++) begin
            rd(reset_tbl[k].addr, b);
            check($sformatf("reset_map_%0h", reset_tbl[k].addr), b, reset_tbl[k].exp);
        end
        check("reset_dr_after", data_ready, 1'b0);

        // Coherent burst
        meas(16'h1234, 16'h0567, 32'h89ABCDEF, 16'h4000);
        rd(8'h03, b);
        check("burst_cnt", b, 8'h01);
        meas(16'hFFFF, 16'h1111, 32'h22223333, 16'h4444);
        for (int k = 0; k < 10; k++) begin
            rd(burst_tbl[k].addr, b);
            check($sformatf("burst_%0h", burst_tbl[k].addr), b, burst_tbl[k].exp);
        end
        check("burst_dr", data_ready, 1'b1);

        // Counter saturation
        for (int k = 0; k < 300; k++) meas(16'(k), 16'(k), 32'(k), 16'(k));
        rd(8'h03, b);
        check("sat_cnt", b, 8'hFF);
        rd(8'h03, b);
        check("sat_cleared", b, 8'h00);

        // Sticky faults
        cyc(0, 8'h00, 0, 0, 0, 0, 0, 1, 0);
        rd(8'h02, b);
        check("ovp_set", b, 8'h01);
        rd(8'h02, b);
        check("ovp_cleared", b, 8'h00);
        cyc(1, 8'h02, 0, 0, 0, 0, 0, 0, 1);
        check("ocp_coincident_read", reg_rdata, 8'h00);
        rd(8'h02, b);
        check("ocp_set_wins", b, 8'h02);

        // Snapshot / measurement collision
        do_reset();
        meas(16'h0050, 16'h0001, 32'h1, 16'h1);
        meas(16'h0080, 16'h0002, 32'h2, 16'h2);
        meas(16'h0100, 16'h0003, 32'h3, 16'h3);
        cyc(1, 8'h03, 1, 16'h0200, 16'h0004, 32'h4, 16'h4, 0, 0);
        check("coll_cnt", reg_rdata, 8'h03);
        rd(8'h04, b); check("coll_snapv_hi", b, 8'h01);
        rd(8'h05, b); check("coll_snapv_lo", b, 8'h00);
        check("coll_dr", data_ready, 1'b1);
        rd(8'h03, b); check("coll_cnt2", b, 8'h01);
        rd(8'h04, b); check("coll_snapv2_hi", b, 8'h02);
        rd(8'h05, b); check("coll_snapv2_lo", b, 8'h00);

        // Unmapped and latency/hold
        rd(8'h0E, b); check("unmapped_0e", b, 8'h00);
        rd(8'hFF, b); check("unmapped_ff", b, 8'h00);
        reg_read = 1; reg_addr = 8'h00;
        model_step(1, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        #2 check("latency_before_edge", reg_rdata, 8'h00);
        @(negedge clk);
        reg_read = 0;
        check("latency_one_clk", reg_rdata, 8'hA5);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 8'h04 + 8'(k), 1, 16'(k), 0, 0, 0, 0, 0);
            check("hold_no_read", reg_rdata, 8'hA5);
        end

        // Random traffic against the model
        for (int n = 0; n < 500; n++) begin
            logic [7:0] a;
            tracking = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            cyc(1'($urandom_range(0, 1)), a, ($urandom_range(0, 9) < 4),
                16'($urandom), 16'($urandom), $urandom, 16'($urandom),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
            check("rand_rdata", reg_rdata, m_rdata);
            check("rand_data_ready", data_ready, m_dr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Register file sitting directly downstream of the SPI slave interface: serves its reg_addr/reg_read requests with reg_rdata.
- Holds live MPPT measurement shadows, latched sticky fault flags and a measurement counter.
- Freezes multi-byte measurements into a coherent snapshot so that a burst read never mixes two samples.

Parameters:
- ID_VALUE, 8'hA5, constant returned at address 0x00
- VERSION, 8'h01, constant returned at address 0x01

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- reg_addr  in  8  register address from SPI slave
- reg_read  in  1  one-cycle read strobe; reg_addr valid in same cycle
- reg_rdata  out  8  registered read data
- meas_valid  in  1  one-cycle pulse: v_pv/i_pv/p_pv/duty valid
- v_pv  in  16  PV voltage code
- i_pv  in  16  PV current code
- p_pv  in  32  PV power code
- duty  in  16  converter duty code
- tracking  in  1  live MPPT tracking flag (level)
- fault_ovp  in  1  over-voltage event pulse
- fault_ocp  in  1  over-current event pulse
- data_ready  out  1  fresh live sample not yet snapshotted

Behaviour:
- Reset (async, rst=1): reg_rdata=0x00; data_ready=0; all live, snapshot and flag registers 0; meas_cnt=0. Reset mid-read aborts; the first read after reset returns reset values.
- Live shadows: on meas_valid, v/i/p/duty copied to live registers; data_ready<=1; meas_cnt increments, saturating at 8'hFF.
- Sticky flags: ovp_f/ocp_f set on their pulse, cleared only by a read of STATUS. A set and a clear in the same cycle leave the flag set.
- Register map (big-endian, hi byte at lower address):
  - 0x00 ID_VALUE
  - 0x01 VERSION
  - 0x02 STATUS = {4'b0, data_ready, tracking, ocp_f, ovp_f}
  - 0x03 MEAS_CNT
  - 0x04/05 snap_v
  - 0x06/07 snap_i
  - 0x08..0x0B snap_p (0x08 = bits 31:24)
  - 0x0C/0D snap_duty
  - 0x0E..0xFF read 0x00
- Read timing: on the clk edge with reg_read=1, reg_rdata<=map[reg_addr]. Latency 1 clk. reg_rdata holds until the next reg_read.
- Address handling: reg_addr wraps 0xFF->0x00 in the upstream block; this block simply decodes it, with no special case.
- Side effects apply at the same edge as the data capture. The returned byte is always the pre-side-effect value.
  - Read 0x02: clears ovp_f/ocp_f (set-wins rule above).
  - Read 0x03 (snapshot trigger): all snap_* <= live values; meas_cnt<=0; data_ready<=0.
- meas_valid coincident with a snapshot trigger:
  - Snapshot captures the old live values.
  - Live registers take the new sample.
  - meas_cnt<=1, data_ready<=1, so the new sample is reported as fresh.
  - Returned MEAS_CNT is the pre-clear count.
- Snapshot registers change only on a snapshot trigger. Reading 0x04..0x0D has no side effects.
- reg_read=0: no state change except meas_valid/fault updates.

Test Plan:
- Reset: assert rst mid-cycle, read 0x00,0x01,0x02,0x04 -> A5, 01, 00, 00; data_ready=0.
- Coherent burst:
  - Stimulus: meas_valid with v=0x1234, i=0x0567, p=0x89ABCDEF, duty=0x4000; read 0x03; apply a second meas_valid with v=0xFFFF; read 0x04..0x0D.
  - Required: 0x03 returns 01; then 12 34 05 67 89 AB CD EF 40 00; data_ready=1.
- Counter saturation: 300 meas_valid pulses, read 0x03 -> FF; read 0x03 again -> 00.
- Sticky fault clear-on-read:
  - fault_ovp pulse; read 0x02 -> 0x01 (tracking=0); read 0x02 again -> 0x00.
  - fault_ocp pulse in the same cycle as a STATUS read -> next STATUS read shows bit1=1.
- Snapshot/measurement collision:
  - Live v=0x0100 with 3 samples counted; meas_valid (v=0x0200) coincident with a read of 0x03.
  - Required: returns 03; snap_v reads 01 00; data_ready=1; next read of 0x03 -> 01, snap_v reads 02 00.
- Unmapped and latency: read 0x0E and 0xFF -> 00. Confirm reg_rdata updates exactly 1 clk after reg_read and holds while reg_read=0.
